// File: rtl/ram_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ram_arb_pkg
// Purpose  : Shared types and constants for the two-port RAM arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package ram_arb_pkg;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    // Byte-offset bits inside one 64-bit RAM word
    localparam int WORD_OFFSET_BITS = 3;

    typedef logic port_id_t;

    localparam logic [31:0] DEFAULT_BASE_ADDRESS = 32'h0000_1000;

endpackage
`default_nettype wire

// File: rtl/ram_arb_rr2.sv
`default_nettype none
// ============================================================================
// Module   : ram_arb_rr2
// Purpose  : Two-input round-robin selector; last_grant resets to 1 so port 0 wins first.
// Revision : 1.0 - initial release
// ============================================================================
module ram_arb_rr2
    import ram_arb_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       valid0,
    input  logic       valid1,
    input  logic       update,
    output logic [1:0] grant
);

    port_id_t r_last_grant;

    always_comb begin
        grant = 2'b00;
        if (valid0 && valid1) begin
            grant = r_last_grant ? 2'b01 : 2'b10;
        end else if (valid0) begin
            grant = 2'b01;
        end else if (valid1) begin
            grant = 2'b10;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_grant <= 1'b1;
        end else if (update && (grant != 2'b00)) begin
            r_last_grant <= grant[1];
        end
    end

endmodule
`default_nettype wire

// File: rtl/ram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : ram_port_arbiter
// Purpose  : Round-robin two-requester controller for a single-port 64-bit synchronous RAM.
// Revision : 1.0 - initial release
// ============================================================================
module ram_port_arbiter
    import ram_arb_pkg::*;
#(
    parameter int          DATA_WIDTH   = 64,
    parameter int          ADDR_WIDTH   = 10,
    parameter logic [31:0] BASE_ADDRESS = DEFAULT_BASE_ADDRESS
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req0_valid,
    input  logic                  req0_we,
    input  logic [31:0]           req0_addr,
    input  logic [DATA_WIDTH-1:0] req0_wdata,
    output logic                  req0_ready,
    output logic                  resp0_valid,
    output logic                  resp0_err,
    output logic [DATA_WIDTH-1:0] resp0_rdata,
    input  logic                  req1_valid,
    input  logic                  req1_we,
    input  logic [31:0]           req1_addr,
    input  logic [DATA_WIDTH-1:0] req1_wdata,
    output logic                  req1_ready,
    output logic                  resp1_valid,
    output logic                  resp1_err,
    output logic [DATA_WIDTH-1:0] resp1_rdata,
    output logic [ADDR_WIDTH-1:0] ram_address,
    output logic                  ram_cs,
    output logic                  ram_we,
    output logic                  ram_oe,
    inout  wire  [DATA_WIDTH-1:0] ram_data,
    output logic                  busy
);

    localparam logic [31:0] SPAN_BYTES = 32'd1 << (ADDR_WIDTH + WORD_OFFSET_BITS);

    state_t                          r_state;
    state_t                          w_state_next;
    logic   [1:0]                    w_grant;
    logic                            w_idle;
    logic                            w_accept;
    port_id_t                        w_sel_port;
    logic                            w_sel_we;
    logic   [31:0]                   w_sel_addr;
    logic   [31:0]                   w_offset;
    logic   [DATA_WIDTH-1:0]         w_sel_wdata;
    logic                            w_addr_err;

    port_id_t                        r_port;
    logic                            r_we;
    logic                            r_err;
    logic   [DATA_WIDTH-1:0]         r_wdata;
    logic   [ADDR_WIDTH-1:0]         r_ram_address;
    logic                            r_ram_cs;
    logic                            r_ram_we;
    logic                            r_ram_oe;
    logic   [1:0]                    r_resp_valid;
    logic   [1:0]                    r_resp_err;
    logic   [1:0][DATA_WIDTH-1:0]    r_rdata;

    ram_arb_rr2 u_rr (
        .clk    (clk),
        .rst_n  (rst_n),
        .valid0 (req0_valid),
        .valid1 (req1_valid),
        .update (w_accept),
        .grant  (w_grant)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_state_next = ACCESS;
            ACCESS:  w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_comb begin
        w_idle     = (r_state == IDLE);
        req0_ready = w_idle && w_grant[0];
        req1_ready = w_idle && w_grant[1];
        w_accept   = req0_ready || req1_ready;
        busy       = !w_idle;
    end

    // Address decode of whichever request the selector currently favours
    always_comb begin
        w_sel_port  = w_grant[1];
        w_sel_we    = w_sel_port ? req1_we    : req0_we;
        w_sel_addr  = w_sel_port ? req1_addr  : req0_addr;
        w_sel_wdata = w_sel_port ? req1_wdata : req0_wdata;
        w_offset    = w_sel_addr - BASE_ADDRESS;
        w_addr_err  = (w_sel_addr < BASE_ADDRESS) || (w_offset >= SPAN_BYTES) ||
                      (w_sel_addr[WORD_OFFSET_BITS-1:0] != '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_port        <= 1'b0;
            r_we          <= 1'b0;
            r_err         <= 1'b0;
            r_wdata       <= '0;
            r_ram_address <= '0;
            r_ram_cs      <= 1'b0;
            r_ram_we      <= 1'b0;
            r_ram_oe      <= 1'b0;
            r_resp_valid  <= 2'b00;
            r_resp_err    <= 2'b00;
            r_rdata       <= '0;
        end else begin
            r_resp_valid <= 2'b00;
            r_resp_err   <= 2'b00;
            r_ram_cs     <= 1'b0;
            r_ram_we     <= 1'b0;
            r_ram_oe     <= 1'b0;
            if (w_accept) begin
                r_port   <= w_sel_port;
                r_we     <= w_sel_we;
                r_err    <= w_addr_err;
                r_wdata  <= w_sel_wdata;
                r_ram_cs <= !w_addr_err;
                r_ram_we <= w_sel_we && !w_addr_err;
                r_ram_oe <= !w_sel_we && !w_addr_err;
                if (!w_addr_err) begin
                    r_ram_address <= w_offset[WORD_OFFSET_BITS +: ADDR_WIDTH];
                end
            end else if (r_state == ACCESS) begin
                r_resp_valid[r_port] <= 1'b1;
                r_resp_err[r_port]   <= r_err;
                // RAM read data became valid after the mid-cycle falling edge
                if (!r_err && !r_we) begin
                    r_rdata[r_port] <= ram_data;
                end
            end
        end
    end

    assign ram_data    = (r_ram_cs && r_ram_we) ? r_wdata : {DATA_WIDTH{1'bz}};
    assign ram_address = r_ram_address;
    assign ram_cs      = r_ram_cs;
    assign ram_we      = r_ram_we;
    assign ram_oe      = r_ram_oe;
    assign resp0_valid = r_resp_valid[0];
    assign resp1_valid = r_resp_valid[1];
    assign resp0_err   = r_resp_err[0];
    assign resp1_err   = r_resp_err[1];
    assign resp0_rdata = r_rdata[0];
    assign resp1_rdata = r_rdata[1];

endmodule
`default_nettype wire
